// File: rtl/eth_frame_former_v2.sv
// Ethernet frame former: header, FIFO payload, optional zero pad, trailer beat with tlast.
// Optional feature: define FFM_MIN_PAD_EN to pad short frames up to MIN_FRAME header+payload bytes.
module eth_frame_former_v2 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 14,
  parameter logic [23:0] TRAILER    = 24'h005704,
  parameter int unsigned MIN_FRAME  = 60
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    enable,
  input  logic                    in_empty,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_rd_en,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tvalid,
  output logic                    M_AXIS_tlast,
  input  logic                    M_AXIS_tready,
  input  logic [47:0]             Destination_Address,
  input  logic [47:0]             Source_Address,
  input  logic [15:0]             Link_Type,
  input  logic [15:0]             SyncWord,
  input  logic [LEN_WIDTH-1:0]    Packet_Size,
  output logic [31:0]             frame_count,
  output logic [15:0]             underrun_cycles,
  output logic [2:0]              FFMState
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned HDR_BEATS = 16 / BYTES;
  localparam logic [1:0]  HDR_LAST  = 2'(HDR_BEATS - 1);
  localparam logic [BYTES-1:0]      KEEP_ALL = '1;
  localparam logic [BYTES-1:0]      KEEP_TRL = {{(BYTES-3){1'b0}}, 3'b111};
  localparam logic [DATA_WIDTH-1:0] TRL_DATA = {{(DATA_WIDTH-24){1'b0}}, TRAILER};
`ifdef FFM_MIN_PAD_EN
  localparam logic [LEN_WIDTH-1:0] MIN_BEATS = LEN_WIDTH'((MIN_FRAME - 16 + BYTES - 1) / BYTES);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
`ifdef FFM_MIN_PAD_EN
    S_PAD     = 3'd3,
`endif
    S_TRAILER = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [127:0]           hdr_q, hdr_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   pay_cnt_q, pay_cnt_d;
  logic [1:0]             hdr_idx_q, hdr_idx_d;
`ifdef FFM_MIN_PAD_EN
  logic [LEN_WIDTH-1:0]   pad_q, pad_d;
  logic [LEN_WIDTH-1:0]   pad_cnt_q, pad_cnt_d;
`endif
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [BYTES-1:0]       tkeep_q, tkeep_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;
  logic [15:0]            underrun_q, underrun_d;

  logic                   adv;
  logic [127:0]           hdr_sh;
  state_e                 after_body;

  assign adv = !tvalid_q || M_AXIS_tready;
  assign in_rd_en = (state_q == S_PAYLOAD) && adv && !in_empty;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    hdr_idx_d   = hdr_idx_q;
`ifdef FFM_MIN_PAD_EN
    pad_d       = pad_q;
    pad_cnt_d   = pad_cnt_q;
    after_body  = (pad_q != '0) ? S_PAD : S_TRAILER;
`else
    after_body  = S_TRAILER;
`endif
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = underrun_q;
    hdr_sh      = hdr_q >> (32'(hdr_idx_q) * DATA_WIDTH);

    case (state_q)
      S_IDLE: begin
        if (enable && !in_empty && adv) begin
          hdr_d     = {SyncWord, Link_Type, Source_Address, Destination_Address};
          len_d     = Packet_Size;
`ifdef FFM_MIN_PAD_EN
          pad_d     = (Packet_Size >= MIN_BEATS) ? '0 : MIN_BEATS - Packet_Size;
          pad_cnt_d = '0;
`endif
          pay_cnt_d = '0;
          hdr_idx_d = 2'd1;
          tdata_d   = hdr_d[DATA_WIDTH-1:0];
          tkeep_d   = KEEP_ALL;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (adv) begin
          tdata_d   = hdr_sh[DATA_WIDTH-1:0];
          tkeep_d   = KEEP_ALL;
          tvalid_d  = 1'b1;
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == HDR_LAST) state_d = (len_q != '0) ? S_PAYLOAD : after_body;
        end
      end
      S_PAYLOAD: begin
        if (adv) begin
          if (!in_empty) begin
            tdata_d   = in_data;
            tkeep_d   = KEEP_ALL;
            tvalid_d  = 1'b1;
            pay_cnt_d = pay_cnt_q + 1'b1;
            if (pay_cnt_d == len_q) state_d = after_body;
          end else begin
            tvalid_d = 1'b0;
            if (underrun_q != '1) underrun_d = underrun_q + 16'd1;
          end
        end
      end
`ifdef FFM_MIN_PAD_EN
      S_PAD: begin
        if (adv) begin
          tdata_d   = '0;
          tkeep_d   = KEEP_ALL;
          tvalid_d  = 1'b1;
          pad_cnt_d = pad_cnt_q + 1'b1;
          if (pad_cnt_d == pad_q) state_d = S_TRAILER;
        end
      end
`endif
      S_TRAILER: begin
        // tlast_q marks the trailer as already loaded and awaiting its handshake
        if (tlast_q) begin
          if (M_AXIS_tready) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 32'd1;
            state_d     = S_IDLE;
          end
        end else if (adv) begin
          tdata_d  = TRL_DATA;
          tkeep_d  = KEEP_TRL;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      len_q       <= '0;
      pay_cnt_q   <= '0;
      hdr_idx_q   <= '0;
`ifdef FFM_MIN_PAD_EN
      pad_q       <= '0;
      pad_cnt_q   <= '0;
`endif
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      frame_cnt_q <= '0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
`ifdef FFM_MIN_PAD_EN
      pad_q       <= pad_d;
      pad_cnt_q   <= pad_cnt_d;
`endif
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

  assign M_AXIS_tdata    = tdata_q;
  assign M_AXIS_tkeep    = tkeep_q;
  assign M_AXIS_tvalid   = tvalid_q;
  assign M_AXIS_tlast    = tlast_q;
  assign frame_count     = frame_cnt_q;
  assign underrun_cycles = underrun_q;
  assign FFMState        = state_q;

endmodule
